// File: rtl/mcfifo_read_scheduler_pkg.sv
// Shared types and helpers for the multi-channel FIFO read scheduler.
package mcfifo_read_scheduler_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        EVAL = 2'd2,
        GAP  = 2'd3
    } state_e;

    // Ceil(log2(n)), never below 1 so a single-channel build still has a select bit
    function automatic int clogb2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mcfifo_rr_pick.sv
// Next-channel picker: a pending skip channel wins when enabled, otherwise the
// first enabled channel after the current one (wrapping, current one last).
import mcfifo_read_scheduler_pkg::*;

module mcfifo_rr_pick #(
    parameter int Channels = 16,
    parameter int CW       = clogb2(Channels)
) (
    input  logic [Channels-1:0] en,
    input  logic [CW-1:0]       cur,
    input  logic                skip_req,
    input  logic [CW-1:0]       skip_ch,
    output logic [CW-1:0]       nxt,
    output logic                nxt_vld,
    output logic                skip_hit
);

    logic [CW-1:0] cand;

    // Scan farthest-to-nearest so the nearest enabled channel is the last writer
    always_comb begin
        nxt      = cur;
        nxt_vld  = 1'b0;
        skip_hit = 1'b0;
        cand     = '0;
        for (int i = Channels; i >= 1; i--) begin
            cand = CW'((int'(cur) + i) % Channels);
            if (en[cand]) begin
                nxt     = cand;
                nxt_vld = 1'b1;
            end
        end
        if (skip_req && (int'(skip_ch) < Channels) && en[skip_ch]) begin
            nxt      = skip_ch;
            nxt_vld  = 1'b1;
            skip_hit = 1'b1;
        end
    end

endmodule

// File: rtl/mcfifo_read_scheduler.sv
// Multi-channel FIFO read scheduler: walks enabled channels, reads up to a
// burst of words per grant (one read every other cycle) into a one-word
// output register with a valid/ready handshake.
import mcfifo_read_scheduler_pkg::*;

module mcfifo_read_scheduler #(
    parameter  int Channels = 16,
    parameter  int Width    = 32,
    localparam int CW       = clogb2(Channels)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [Channels-1:0] EN,
    input  logic [3:0]          BURST,
    output logic [CW-1:0]       RCS,
    output logic                RD,
    input  logic                REMPTY,
    input  logic [Width-1:0]    DI,
    input  logic                SKIP,
    input  logic [CW-1:0]       STT,
    output logic                OVALID,
    input  logic                ORDY,
    output logic [Width-1:0]    ODATA,
    output logic [CW-1:0]       OCH,
    output logic                BUSY
);

    state_e           state_q, state_d;
    logic [CW-1:0]    rcs_q, rcs_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             skip_pend_q, skip_pend_d;
    logic [CW-1:0]    skip_ch_q, skip_ch_d;
    logic             ovalid_q, ovalid_d;
    logic [Width-1:0] odata_q, odata_d;
    logic [CW-1:0]    och_q, och_d;

    logic [CW-1:0]    nxt_ch;
    logic             nxt_vld;
    logic             skip_hit;
    logic             chg;
    logic [4:0]       burst_lim;

    mcfifo_rr_pick #(
        .Channels (Channels),
        .CW       (CW)
    ) u_pick (
        .en       (EN),
        .cur      (rcs_q),
        .skip_req (skip_pend_q),
        .skip_ch  (skip_ch_q),
        .nxt      (nxt_ch),
        .nxt_vld  (nxt_vld),
        .skip_hit (skip_hit)
    );

    // State register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Scheduler datapath registers: channel, burst count, skip capture, output word
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rcs_q       <= '0;
            cnt_q       <= '0;
            skip_pend_q <= 1'b0;
            skip_ch_q   <= '0;
            ovalid_q    <= 1'b0;
            odata_q     <= '0;
            och_q       <= '0;
        end else begin
            rcs_q       <= rcs_d;
            cnt_q       <= cnt_d;
            skip_pend_q <= skip_pend_d;
            skip_ch_q   <= skip_ch_d;
            ovalid_q    <= ovalid_d;
            odata_q     <= odata_d;
            och_q       <= och_d;
        end
    end

    // Next state: decide when to move to a new channel and track the burst count
    always_comb begin
        state_d   = state_q;
        rcs_d     = rcs_q;
        cnt_d     = cnt_q;
        chg       = 1'b0;
        burst_lim = {BURST == 4'd0, BURST};
        unique case (state_q)
            IDLE: if (|EN) chg = 1'b1;
            SEL:  state_d = EVAL;
            EVAL: begin
                if (REMPTY || !EN[rcs_q]) chg = 1'b1;
                else if (RD) begin
                    cnt_d   = cnt_q + 5'd1;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (cnt_q == burst_lim) chg = 1'b1;
                else                    state_d = EVAL;
            end
            default: state_d = IDLE;
        endcase
        if (chg) begin
            cnt_d = '0;
            if (nxt_vld) begin
                rcs_d   = nxt_ch;
                state_d = SEL;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // Skip capture and output register; a new SKIP beats a same-cycle take
    always_comb begin
        skip_pend_d = SKIP | (skip_pend_q & ~(chg & nxt_vld & skip_hit));
        skip_ch_d   = SKIP ? STT : skip_ch_q;
        ovalid_d    = RD | (ovalid_q & ~ORDY);
        odata_d     = RD ? DI : odata_q;
        och_d       = RD ? rcs_q : och_q;
    end

    // Outputs: read strobe only in EVAL with data present and room downstream
    always_comb begin
        RD   = 1'b0;
        BUSY = (state_q != IDLE);
        if ((state_q == EVAL) && !REMPTY && EN[rcs_q] && (!ovalid_q || ORDY)) RD = 1'b1;
    end

    assign RCS    = rcs_q;
    assign OVALID = ovalid_q;
    assign ODATA  = odata_q;
    assign OCH    = och_q;

endmodule

// File: tb/tb_mcfifo_read_scheduler.sv
// Bench for mcfifo_read_scheduler: per-channel FIFO model with registered
// empty/head outputs, a scoreboard that checks every delivered word against
// the words loaded for its channel, protocol invariants each cycle, and
// directed scenarios with hand-computed channel orderings.
module tb_mcfifo_read_scheduler;

    localparam int CH = 16;
    localparam int W  = 32;

    logic          CLK    = 1'b0;
    logic          RESET  = 1'b1;
    logic [CH-1:0] EN     = '0;
    logic [3:0]    BURST  = 4'd0;
    logic [3:0]    RCS;
    logic          RD;
    logic          REMPTY = 1'b1;
    logic [W-1:0]  DI     = '0;
    logic          SKIP   = 1'b0;
    logic [3:0]    STT    = 4'd0;
    logic          OVALID;
    logic          ORDY   = 1'b1;
    logic [W-1:0]  ODATA;
    logic [3:0]    OCH;
    logic          BUSY;

    mcfifo_read_scheduler #(.Channels(CH), .Width(W)) dut (
        .CLK(CLK), .RESET(RESET), .EN(EN), .BURST(BURST), .RCS(RCS), .RD(RD),
        .REMPTY(REMPTY), .DI(DI), .SKIP(SKIP), .STT(STT), .OVALID(OVALID),
        .ORDY(ORDY), .ODATA(ODATA), .OCH(OCH), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // FIFO contents per channel; fwr = words loaded, frd = words popped by RD
    logic [W-1:0] fmem [CH][16];
    logic [3:0]   fwr  [CH] = '{default: 4'd0};
    logic [3:0]   frd  [CH] = '{default: 4'd0};
    logic [3:0]   dlv  [CH] = '{default: 4'd0};
    logic [3:0]   disc [CH] = '{default: 4'd0};

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int och_log[$];
    int rcs_log[$];
    int rd_cyc[$];
    logic         last_rd    = 1'b0;
    logic [3:0]   last_rcs   = 4'd0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data  = '0;
    logic [3:0]   prev_och   = 4'd0;

    // FIFO: empty flag and head word register one cycle behind RCS / pops
    always @(posedge CLK) begin
        REMPTY <= (frd[RCS] >= fwr[RCS]);
        DI     <= fmem[RCS][frd[RCS]];
        if (RD) frd[RCS] <= frd[RCS] + 4'd1;
    end

    function automatic logic [W-1:0] word(input logic [3:0] c, input logic [3:0] i);
        return {16'hA500, 4'h0, c, 4'h0, i};
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic load(input logic [3:0] c, input int n);
        for (int i = 0; i < n; i++) begin
            fmem[c][fwr[c]] = word(c, fwr[c]);
            fwr[c] = fwr[c] + 4'd1;
        end
    endtask

    function automatic logic drained();
        logic d;
        d = 1'b1;
        for (int c = 0; c < CH; c++)
            if ((dlv[c] + disc[c]) != fwr[c]) d = 1'b0;
        return d;
    endfunction

    // One cycle: check what the coming rising edge will see, then move to the falling edge
    task automatic tick();
        if (RESET) begin
            last_rd    = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (RD) begin
                chk("rd_back_to_back", last_rd, 0);
                chk("rd_fifo_nonempty", frd[RCS] < fwr[RCS], 1);
                chk("rd_channel_enabled", EN[RCS], 1);
                rd_cyc.push_back(cyc);
            end
            last_rd = RD;
            if (RCS != last_rcs) rcs_log.push_back(int'(RCS));
            if (prev_stall) begin
                chk("hold_odata", ODATA, prev_data);
                chk("hold_och", OCH, prev_och);
            end
            if (OVALID && ORDY) begin
                chk("deliver_pending", (dlv[OCH] + disc[OCH]) < fwr[OCH], 1);
                chk("deliver_data", ODATA, fmem[OCH][dlv[OCH] + disc[OCH]]);
                och_log.push_back(int'(OCH));
                dlv[OCH] = dlv[OCH] + 4'd1;
            end
            prev_stall = OVALID && !ORDY;
            prev_data  = ODATA;
            prev_och   = OCH;
        end
        last_rcs = RCS;
        cyc++;
        @(negedge CLK);
    endtask

    task automatic wait_drained(input string nm, input int maxc);
        int n;
        n = 0;
        while (!drained() && n < maxc) begin
            tick();
            n++;
        end
        chk(nm, drained(), 1);
    endtask

    task automatic wait_rd(input string nm, input int maxc);
        int n, base;
        n = 0;
        base = rd_cyc.size();
        while (rd_cyc.size() == base && n < maxc) begin
            tick();
            n++;
        end
        chk(nm, rd_cyc.size() > base, 1);
    endtask

    task automatic do_reset();
        EN    = '0;
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    task automatic chk_seq(input string nm, input int base, input int exp[]);
        for (int i = 0; i < exp.size(); i++)
            if (base + i < och_log.size()) chk(nm, och_log[base + i], exp[i]);
    endtask

    initial begin
        int ob, rb, rdb, n;
        int exp_a[] = '{2, 2, 5, 5, 2, 5};
        int exp_c[] = '{3, 3, 7, 3, 3, 4, 4};

        // Reset values
        repeat (3) tick();
        chk("rst_rcs", RCS, 0);
        chk("rst_rd", RD, 0);
        chk("rst_ovalid", OVALID, 0);
        chk("rst_odata", ODATA, 0);
        chk("rst_och", OCH, 0);
        chk("rst_busy", BUSY, 0);
        RESET = 1'b0;

        // Nothing enabled stays idle; enabling channel 9 selects it next cycle
        repeat (5) begin
            tick();
            chk("idle_busy", BUSY, 0);
        end
        EN[9] = 1'b1;
        tick();
        chk("en9_busy", BUSY, 1);
        chk("en9_rcs", RCS, 9);
        do_reset();

        // Channels 2 and 5, three words each, burst of two
        load(4'd2, 3);
        load(4'd5, 3);
        BURST = 4'd2;
        ob  = och_log.size();
        rdb = rd_cyc.size();
        EN  = 16'h0024;
        wait_drained("a_drain", 200);
        chk("a_count", och_log.size() - ob, 6);
        chk_seq("a_och_seq", ob, exp_a);
        if (rd_cyc.size() >= rdb + 2) chk("a_rd_spacing", rd_cyc[rdb + 1] - rd_cyc[rdb], 2);
        chk("a_first_word", fmem[2][0], 32'hA500_0200);
        do_reset();

        // Only channel 15 holds data with every channel enabled
        load(4'd15, 2);
        BURST = 4'd1;
        ob = och_log.size();
        rb = rcs_log.size();
        EN = '1;
        wait_drained("b_drain", 300);
        chk("b_count", och_log.size() - ob, 2);
        chk("b_scan_len", rcs_log.size() >= rb + 31, 1);
        for (int k = 0; k < 31; k++)
            if (rb + k < rcs_log.size()) chk("b_rcs_scan", rcs_log[rb + k], (k < 15) ? k + 1 : k - 15);
        do_reset();

        // Skip to channel 7 during a channel-3 burst
        load(4'd3, 4);
        load(4'd4, 2);
        load(4'd7, 1);
        BURST = 4'd2;
        ob = och_log.size();
        rb = rcs_log.size();
        EN = 16'h0098;
        wait_rd("c_first_rd", 50);
        SKIP = 1'b1;
        STT  = 4'd7;
        tick();
        SKIP = 1'b0;
        wait_drained("c_drain", 300);
        chk("c_count", och_log.size() - ob, 7);
        chk_seq("c_och_seq", ob, exp_c);
        if (rcs_log.size() >= rb + 2) chk("c_rcs_after_3", rcs_log[rb + 1], 7);
        do_reset();

        // Downstream stall for ten cycles with a word held
        load(4'd1, 4);
        BURST = 4'd0;
        ORDY  = 1'b0;
        ob = och_log.size();
        EN = 16'h0002;
        n = 0;
        while (!OVALID && n < 50) begin
            tick();
            n++;
        end
        chk("d_ovalid", OVALID, 1);
        rdb = rd_cyc.size();
        repeat (10) tick();
        chk("d_no_rd", rd_cyc.size() - rdb, 0);
        chk("d_hold_word", ODATA, 32'hA500_0100);
        chk("d_hold_ch", OCH, 1);
        ORDY = 1'b1;
        wait_drained("d_drain", 100);
        chk("d_count", och_log.size() - ob, 4);
        do_reset();

        // Reset in the GAP right after a read discards the undelivered word
        load(4'd6, 3);
        ob = och_log.size();
        EN = 16'h0040;
        wait_rd("e_first_rd", 50);
        chk("e_ovalid_before", OVALID, 1);
        RESET = 1'b1;
        #1;
        chk("e_rst_rd", RD, 0);
        chk("e_rst_ovalid", OVALID, 0);
        chk("e_rst_busy", BUSY, 0);
        disc[6] = 4'd1;
        tick();
        tick();
        RESET = 1'b0;
        #1;
        chk("e_idle_after", BUSY, 0);
        wait_drained("e_drain", 100);
        chk("e_count", och_log.size() - ob, 2);
        EN = '0;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
